// File: rtl/victim_way_selector_if.sv
// victim_way_selector_if
// Groups the miss request, status-array read/write and refill handshake
// signals of the instruction-cache victim selector.
//   master : the victim selector (drives o_*, samples i_*)
//   slave  : the surrounding cache (drives i_*, samples o_*)
// Signal names keep their block-level i_/o_ prefixes, seen from the selector.
interface victim_way_selector_if #(
  parameter int SA_WORD_WIDTH = 8,
  parameter int NUM_WAYS      = 4,
  parameter int SET_IDX_WIDTH = 6
) ();

  // miss request
  logic                     i_miss_valid;
  logic [SET_IDX_WIDTH-1:0] i_miss_set;
  logic                     o_miss_ready;

  // status-array read port (one-cycle read latency)
  logic                     o_sa_r_en;
  logic [SET_IDX_WIDTH-1:0] o_sa_r_addr;
  logic [SA_WORD_WIDTH-1:0] i_sa_data;

  // refill engine handshake
  logic                     o_refill_valid;
  logic [NUM_WAYS-1:0]      o_refill_way;
  logic [SET_IDX_WIDTH-1:0] o_refill_set;
  logic                     i_refill_ready;
  logic                     i_refill_done;

  // status-array write port
  logic                     o_sa_w_en;
  logic [SET_IDX_WIDTH-1:0] o_sa_w_addr;
  logic [SA_WORD_WIDTH-1:0] o_sa_w_data;
  logic [NUM_WAYS-1:0]      o_sa_w_mask;

  // hit-path stall
  logic                     o_busy;

  modport master (
    input  i_miss_valid, i_miss_set, i_sa_data, i_refill_ready, i_refill_done,
    output o_miss_ready, o_sa_r_en, o_sa_r_addr, o_refill_valid, o_refill_way,
           o_refill_set, o_sa_w_en, o_sa_w_addr, o_sa_w_data, o_sa_w_mask, o_busy
  );

  modport slave (
    output i_miss_valid, i_miss_set, i_sa_data, i_refill_ready, i_refill_done,
    input  o_miss_ready, o_sa_r_en, o_sa_r_addr, o_refill_valid, o_refill_way,
           o_refill_set, o_sa_w_en, o_sa_w_addr, o_sa_w_data, o_sa_w_mask, o_busy
  );

endinterface

// File: rtl/victim_way_selector.sv
// victim_way_selector
// Miss-side replacement logic of the blocking instruction cache. For each
// accepted miss it reads the set's status word (valid + use bit per way),
// selects a victim (first invalid way, else first way with a clear effective
// use bit, else way 0), requests a refill of that way, waits for the refill
// to finish and writes back the updated valid/use bits.
// Ports:
//   i_clk  : clock, rising edge
//   i_rstn : synchronous active-low reset
//   bus    : victim_way_selector_if.master (miss, status array, refill, busy)
// Status word layout: way k -> bit 2k+1 = use, bit 2k = valid.
module victim_way_selector #(
  parameter int SA_WORD_WIDTH = 8,
  parameter int NUM_WAYS      = 4,
  parameter int SET_IDX_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  victim_way_selector_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_SEL  = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_WR   = 3'd5
  } state_t;

  state_t                   state_reg, state_next;
  logic [SET_IDX_WIDTH-1:0] set_reg, set_next;
  logic [NUM_WAYS-1:0]      valid_reg, valid_next;
  logic [NUM_WAYS-1:0]      eff_use_reg, eff_use_next;
  logic [NUM_WAYS-1:0]      victim_reg, victim_next;

  // decoded view of the incoming status word
  logic [NUM_WAYS-1:0]      sa_valid;
  logic [NUM_WAYS-1:0]      sa_eff_use;
  logic [NUM_WAYS-1:0]      victim_sel;

  // write-back word
  logic [NUM_WAYS-1:0]      new_valid;
  logic [NUM_WAYS-1:0]      use_or;
  logic [NUM_WAYS-1:0]      new_use;
  logic [SA_WORD_WIDTH-1:0] w_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_decode
      assign sa_valid[gi]   = bus.i_sa_data[2*gi];
      // a use bit on an invalid way carries no information
      assign sa_eff_use[gi] = bus.i_sa_data[2*gi+1] & bus.i_sa_data[2*gi];
    end
  endgenerate

  // Victim priority. Scanning from the highest way down lets the lowest
  // matching way win; the invalid-way scan runs last so it overrides the
  // clear-use scan.
  always_comb begin
    victim_sel = NUM_WAYS'(1);
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (!sa_eff_use[k]) begin
        victim_sel = NUM_WAYS'(1) << k;
      end
    end
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (!sa_valid[k]) begin
        victim_sel = NUM_WAYS'(1) << k;
      end
    end
  end

  // Write-back: victim becomes valid and used. When that would leave every
  // way marked used, the use bits restart with only the victim set.
  assign new_valid = valid_reg | victim_reg;
  assign use_or    = eff_use_reg | victim_reg;
  assign new_use   = (&use_or) ? victim_reg : use_or;

  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_wdata
      assign w_data[2*gi+1] = new_use[gi];
      assign w_data[2*gi]   = new_valid[gi];
    end
  endgenerate

  // state and latched miss context
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_reg   <= S_IDLE;
      set_reg     <= '0;
      valid_reg   <= '0;
      eff_use_reg <= '0;
      victim_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      set_reg     <= set_next;
      valid_reg   <= valid_next;
      eff_use_reg <= eff_use_next;
      victim_reg  <= victim_next;
    end
  end

  // next-state and outputs
  always_comb begin
    state_next         = state_reg;
    set_next           = set_reg;
    valid_next         = valid_reg;
    eff_use_next       = eff_use_reg;
    victim_next        = victim_reg;

    bus.o_miss_ready   = 1'b0;
    bus.o_sa_r_en      = 1'b0;
    bus.o_sa_r_addr    = '0;
    bus.o_refill_valid = 1'b0;
    bus.o_refill_way   = '0;
    bus.o_refill_set   = '0;
    bus.o_sa_w_en      = 1'b0;
    bus.o_sa_w_addr    = '0;
    bus.o_sa_w_data    = '0;
    bus.o_sa_w_mask    = '1;
    bus.o_busy         = (state_reg != S_IDLE);

    unique case (state_reg)
      S_IDLE: begin
        // ready is held low for as long as reset is applied
        bus.o_miss_ready = i_rstn;
        if (bus.i_miss_valid) begin
          set_next   = bus.i_miss_set;
          state_next = S_RD;
        end
      end
      S_RD: begin
        bus.o_sa_r_en   = 1'b1;
        bus.o_sa_r_addr = set_reg;
        state_next      = S_SEL;
      end
      S_SEL: begin
        // read data is present this cycle; this is the only copy used
        valid_next   = sa_valid;
        eff_use_next = sa_eff_use;
        victim_next  = victim_sel;
        state_next   = S_REQ;
      end
      S_REQ: begin
        bus.o_refill_valid = 1'b1;
        bus.o_refill_way   = victim_reg;
        bus.o_refill_set   = set_reg;
        if (bus.i_refill_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_refill_done) begin
          state_next = S_WR;
        end
      end
      S_WR: begin
        bus.o_sa_w_en   = 1'b1;
        bus.o_sa_w_addr = set_reg;
        bus.o_sa_w_data = w_data;
        state_next      = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_victim_way_selector.sv
module tb_victim_way_selector;

  localparam int SAW = 8;
  localparam int NW  = 4;
  localparam int SIW = 6;

  logic clk;
  logic rstn;

  int checks = 0;
  int errors = 0;

  victim_way_selector_if #(.SA_WORD_WIDTH(SAW), .NUM_WAYS(NW), .SET_IDX_WIDTH(SIW)) bus ();

  victim_way_selector #(.SA_WORD_WIDTH(SAW), .NUM_WAYS(NW), .SET_IDX_WIDTH(SIW)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: index of the way to evict, straight from the replacement rules.
  function automatic int ref_victim(input logic [7:0] w);
    for (int k = 0; k < NW; k++) if (w[2*k] == 1'b0) return k;
    for (int k = 0; k < NW; k++) if (w[2*k+1] == 1'b0) return k;
    return 0;
  endfunction

  // Reference: status word written back after refilling way v.
  function automatic logic [7:0] ref_wdata(input logic [7:0] w, input int v);
    bit valid[NW];
    bit used[NW];
    int n_used;
    logic [7:0] r;
    n_used = 0;
    for (int k = 0; k < NW; k++) begin
      valid[k] = w[2*k];
      used[k]  = w[2*k] && w[2*k+1];
    end
    valid[v] = 1;
    used[v]  = 1;
    for (int k = 0; k < NW; k++) n_used += used[k] ? 1 : 0;
    if (n_used == NW) for (int k = 0; k < NW; k++) used[k] = (k == v);
    r = '0;
    for (int k = 0; k < NW; k++) begin
      r[2*k]   = valid[k];
      r[2*k+1] = used[k];
    end
    return r;
  endfunction

  // One complete miss. ready_dly: cycles of REQ with ready low before the
  // handshake. done_dly: WAIT cycles before the done pulse. glitch: also pulse
  // done during REQ (both before and at the handshake), which must be ignored.
  task automatic do_miss(input logic [5:0] set, input logic [7:0] data,
                         input int ready_dly, input int done_dly, input bit glitch);
    int v;
    logic [3:0] exp_way;
    logic [7:0] exp_wd;
    v       = ref_victim(data);
    exp_way = 4'(1 << v);
    exp_wd  = ref_wdata(data, v);

    check("idle_ready", 32'(bus.o_miss_ready), 32'd1);
    check("idle_busy", 32'(bus.o_busy), 32'd0);
    bus.i_miss_valid = 1'b1;
    bus.i_miss_set   = set;
    bus.i_sa_data    = 8'($urandom);
    tick();                                   // edge T -> RD
    bus.i_miss_valid = 1'b0;
    bus.i_miss_set   = 6'($urandom);
    check("rd_en", 32'(bus.o_sa_r_en), 32'd1);
    check("rd_addr", 32'(bus.o_sa_r_addr), 32'(set));
    check("rd_busy", 32'(bus.o_busy), 32'd1);
    check("rd_ready", 32'(bus.o_miss_ready), 32'd0);
    bus.i_sa_data = data;
    tick();                                   // T+1 -> SEL
    check("sel_rv", 32'(bus.o_refill_valid), 32'd0);
    check("sel_ren", 32'(bus.o_sa_r_en), 32'd0);
    tick();                                   // T+2 -> REQ
    bus.i_sa_data = 8'($urandom);
    for (int d = 0; d <= ready_dly; d++) begin
      check("req_valid", 32'(bus.o_refill_valid), 32'd1);
      check("req_way", 32'(bus.o_refill_way), 32'(exp_way));
      check("req_set", 32'(bus.o_refill_set), 32'(set));
      check("req_wen", 32'(bus.o_sa_w_en), 32'd0);
      bus.i_refill_ready = (d == ready_dly);
      bus.i_refill_done  = glitch && (d == 0 || d == ready_dly);
      tick();
    end
    bus.i_refill_ready = 1'b0;
    bus.i_refill_done  = 1'b0;
    for (int d = 0; d <= done_dly; d++) begin
      check("wait_valid", 32'(bus.o_refill_valid), 32'd0);
      check("wait_wen", 32'(bus.o_sa_w_en), 32'd0);
      check("wait_busy", 32'(bus.o_busy), 32'd1);
      bus.i_refill_done = (d == done_dly);
      tick();
    end
    bus.i_refill_done = 1'b0;
    check("wr_en", 32'(bus.o_sa_w_en), 32'd1);
    check("wr_addr", 32'(bus.o_sa_w_addr), 32'(set));
    check("wr_data", 32'(bus.o_sa_w_data), 32'(exp_wd));
    check("wr_mask", 32'(bus.o_sa_w_mask), 32'hF);
    check("wr_busy", 32'(bus.o_busy), 32'd1);
    check("wr_ready", 32'(bus.o_miss_ready), 32'd0);
    tick();
    check("post_ready", 32'(bus.o_miss_ready), 32'd1);
    check("post_wen", 32'(bus.o_sa_w_en), 32'd0);
    $display("miss set=%0d data=%02h ready_dly=%0d done_dly=%0d glitch=%0d -> way=%b wdata=%02h",
             set, data, ready_dly, done_dly, glitch, exp_way, exp_wd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.o_miss_ready), 32'd0);
    check({tag, "_ren"}, 32'(bus.o_sa_r_en), 32'd0);
    check({tag, "_rv"}, 32'(bus.o_refill_valid), 32'd0);
    check({tag, "_way"}, 32'(bus.o_refill_way), 32'd0);
    check({tag, "_rset"}, 32'(bus.o_refill_set), 32'd0);
    check({tag, "_wen"}, 32'(bus.o_sa_w_en), 32'd0);
    check({tag, "_wdata"}, 32'(bus.o_sa_w_data), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    rstn               = 1'b0;
    bus.i_miss_valid   = 1'b0;
    bus.i_miss_set     = '0;
    bus.i_sa_data      = '0;
    bus.i_refill_ready = 1'b0;
    bus.i_refill_done  = 1'b0;

    // reset state
    tick();
    tick();
    check_all_zero("rst");
    rstn = 1'b1;
    #1;
    check("rst_release_ready", 32'(bus.o_miss_ready), 32'd1);
    tick();

    // directed cases from the replacement rules
    do_miss(6'd5,  8'hFB, 0, 0, 1'b0);   // invalid way1 -> 0010, wdata 5D
    do_miss(6'd17, 8'hD5, 0, 0, 1'b0);   // clear use -> way0, D7
    do_miss(6'd0,  8'h00, 0, 0, 1'b0);   // cold -> way0, 03
    do_miss(6'd63, 8'hFF, 0, 0, 1'b0);   // all used -> way0, 57
    check("const_fb", 32'(ref_wdata(8'hFB, ref_victim(8'hFB))), 32'h5D);
    check("const_ff", 32'(ref_wdata(8'hFF, ref_victim(8'hFF))), 32'h57);

    // backpressure with ignored done pulses in REQ
    do_miss(6'd42, 8'h7F, 3, 1, 1'b1);

    // reset during WAIT aborts the miss
    bus.i_miss_valid = 1'b1;
    bus.i_miss_set   = 6'd9;
    tick();
    bus.i_miss_valid = 1'b0;
    tick();
    bus.i_sa_data = 8'h3C;
    tick();
    bus.i_refill_ready = 1'b1;
    tick();
    bus.i_refill_ready = 1'b0;
    check("abort_in_wait_busy", 32'(bus.o_busy), 32'd1);
    rstn = 1'b0;
    bus.i_refill_done = 1'b1;
    #1;
    check("abort_ready_low", 32'(bus.o_miss_ready), 32'd0);
    tick();
    bus.i_refill_done = 1'b0;
    check_all_zero("abort");
    rstn = 1'b1;
    bus.i_refill_done = 1'b1;              // stray done in IDLE is ignored
    #1;
    check("abort_release_ready", 32'(bus.o_miss_ready), 32'd1);
    tick();
    bus.i_refill_done = 1'b0;
    check("abort_no_write", 32'(bus.o_sa_w_en), 32'd0);
    $display("reset during WAIT: miss aborted");
    do_miss(6'd9, 8'h3C, 0, 2, 1'b0);

    // randomized misses against the reference model
    for (int n = 0; n < 40; n++) begin
      do_miss(6'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/victim_way_selector.md
# victim_way_selector

Miss-side companion to the hit-path use-bit updater in the instruction cache. On a cache miss it:
- reads the status-array word for the missed set;
- picks the way to evict: invalid ways first, otherwise a way whose use bit is clear;
- hands that way to the refill engine and waits for the refill to complete;
- writes the updated valid and use bits back to the status array.

The cache is blocking, so `o_busy` stalls the hit path for the whole miss.

## Interface
- `SA_WORD_WIDTH`, 8, status-array word width. Way k occupies bits [2k+1:2k]: bit 2k+1 = use, bit 2k = valid.
- `NUM_WAYS`, 4, associativity (fixed at 4).
- `SET_IDX_WIDTH`, 6, set index width.
- `i_clk`  in  1  single clock, rising edge.
- `i_rstn`  in  1  synchronous, active-low reset.
- `i_miss_valid`  in  1  miss request.
- `i_miss_set`  in  `SET_IDX_WIDTH`  set index of the miss.
- `o_miss_ready`  out  1  block accepts a miss (high only in IDLE).
- `o_sa_r_en`  out  1  status-array read enable; data returns one cycle later.
- `o_sa_r_addr`  out  `SET_IDX_WIDTH`  read address.
- `i_sa_data`  in  `SA_WORD_WIDTH`  status-array read data.
- `o_refill_valid`  out  1  refill request.
- `o_refill_way`  out  `NUM_WAYS`  one-hot victim way.
- `o_refill_set`  out  `SET_IDX_WIDTH`  set to refill.
- `i_refill_ready`  in  1  refill engine accepts the request.
- `i_refill_done`  in  1  one-cycle pulse: refill finished.
- `o_sa_w_en`  out  1  status-array write enable.
- `o_sa_w_addr`  out  `SET_IDX_WIDTH`  write address.
- `o_sa_w_data`  out  `SA_WORD_WIDTH`  write data.
- `o_sa_w_mask`  out  `NUM_WAYS`  always all ones.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
FSM states: IDLE, RD, SEL, REQ, WAIT, WR.
- **IDLE:** `o_miss_ready`=1. When `i_miss_valid`=1, latch `i_miss_set` and go to RD.
- **RD:** `o_sa_r_en`=1, `o_sa_r_addr`=latched set; go to SEL.
- **SEL:** capture `i_sa_data`, then compute and register:
  - per-way `valid[k]` = bit 2k;
  - `eff_use[k]` = bit 2k+1 & bit 2k;
  - the victim, chosen by the first matching rule:
    1. lowest-index way with valid=0;
    2. otherwise the lowest-index way with `eff_use`=0;
    3. otherwise way 0.
  - Go to REQ.
- **REQ:** `o_refill_valid`=1 with `o_refill_way` and `o_refill_set` held stable. Go to WAIT in the cycle where `i_refill_ready`=1.
- **WAIT:** hold until `i_refill_done`=1, then go to WR. `i_refill_done` is ignored in every other state.
- **WR:** one cycle, with:
  - `o_sa_w_en`=1, `o_sa_w_addr`=latched set;
  - `new_valid` = `valid` | victim;
  - `u` = `eff_use` | victim; if `u` is all ones, `new_use` = victim only, otherwise `new_use` = `u`;
  - `o_sa_w_data` bit 2k+1 = `new_use[k]`, bit 2k = `new_valid[k]`.
  - Go to IDLE.
- The status word captured in SEL is the only copy used. No hit-path writes can occur while `o_busy`=1.

## Timing
- Reset behaviour:
  - While `i_rstn`=0 at a clock edge: state → IDLE; all registered outputs and latched set/victim/status → 0.
  - `o_miss_ready`=0 while reset is asserted, and 1 in the first cycle after release.
- Miss accepted at edge T (state IDLE, valid&ready):
  - T+1: RD, read issued.
  - T+2: SEL, data sampled.
  - T+3: REQ, first cycle of `o_refill_valid`.
- `o_refill_valid` stays high until the ready handshake; the handshake cycle is the last cycle valid is high.
- Write happens the cycle after `i_refill_done` is sampled in WAIT. `o_miss_ready` returns the following cycle.
- Minimum miss-to-ready-again time, with ready high at T+3 and done at T+4:
  - write at T+5;
  - ready at T+6.
- `i_refill_done` in the same cycle as the REQ handshake is ignored. Done must arrive in WAIT.
- Reset in any state aborts the miss: no write is issued, and the refill outputs drop on the next edge.

## Test plan
- Invalid way first: `i_sa_data`=8'hFB (way1 valid=0) → `o_refill_way`=4'b0010, `o_sa_w_data`=8'h5D (use bits OR to all ones, reset to way1 only).
- Clear use bit: `i_sa_data`=8'hD5 (all valid, only way3 used) → victim 4'b0001, `o_sa_w_data`=8'hD7.
- Cold set: `i_sa_data`=8'h00 → victim 4'b0001, `o_sa_w_data`=8'h03. All used: 8'hFF → victim 4'b0001, `o_sa_w_data`=8'h57.
- Backpressure: `i_refill_ready` low for 3 cycles → `o_refill_valid` held 4 cycles with way and set unchanged; a `i_refill_done` pulse during REQ is ignored (no write).
- Minimum latency: ready always high, done pulsed at T+4 → `o_sa_w_en` only at T+5 with addr=`i_miss_set`, `o_miss_ready` at T+6; `o_busy` high T+1..T+5.
- Reset during WAIT: `i_rstn`=0 for one cycle → no `o_sa_w_en` ever asserted for that miss, all outputs 0, `o_miss_ready`=1 the cycle after release; a new miss then completes normally.
